// File: rtl/intersection_cmd_queue.sv
// intersection_cmd_queue
//   Buffers car add/remove commands from a valid/ready producer and replays
//   them to IntersectionSimulator one at a time.
//   Each issued command is followed by GAP settling cycles.
//   Commands made illegal by the live car counts are discarded and flagged.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmdValid/cmdReady     producer handshake (cmdReady = !full, combinational)
//   cmdOp, cmdPlate       00 remA, 01 remB, 10 addA, 11 addB; plate number
//   numOfCarsA/B          live road counts from the simulator
//   mode, plateIn, action simulator command interface (3'b100 = display)
//   dropped               one-cycle pulse per discarded command
//   occupancy             FIFO entry count
module intersection_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP     = 1,
  parameter int unsigned MAXCARS = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmdValid,
  input  logic [1:0]                 cmdOp,
  input  logic [4:0]                 cmdPlate,
  output logic                       cmdReady,
  input  logic [4:0]                 numOfCarsA,
  input  logic [4:0]                 numOfCarsB,
  output logic [2:0]                 mode,
  output logic [4:0]                 plateIn,
  output logic                       action,
  output logic                       dropped,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned CW = $clog2(GAP + 1);
  localparam logic [2:0]  MODE_DISPLAY = 3'b100;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] plate;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  state_t        state;
  logic [CW-1:0] waitCnt;

  logic          full;
  logic          push;
  logic          pop;
  cmd_t          head;
  logic [4:0]    tgtCount;
  logic          headLegal;

  assign full     = (occupancy == OW'(DEPTH));
  assign cmdReady = !full;
  assign push     = cmdValid && !full;
  assign pop      = (state == IDLE) && (occupancy != '0);
  assign head     = mem[rdPtr];

  // op[0] selects road B, op[1] selects add; counts are used live, no shadow copy
  assign tgtCount  = head.op[0] ? numOfCarsB : numOfCarsA;
  assign headLegal = head.op[1] ? (32'(tgtCount) < MAXCARS) : (tgtCount != 5'd0);

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= cmd_t'{op: cmdOp, plate: cmdPlate};
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy disambiguates full/empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Command sequencer: pop/check in IDLE, one-cycle action in ISSUE, settle in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      mode    <= MODE_DISPLAY;
      plateIn <= 5'd0;
      action  <= 1'b0;
      dropped <= 1'b0;
    end else begin
      action  <= 1'b0;
      dropped <= 1'b0;
      case (state)
        IDLE: begin
          mode <= MODE_DISPLAY;
          if (pop) begin
            if (headLegal) begin
              mode    <= {1'b0, head.op};
              plateIn <= head.plate;
              action  <= 1'b1;
              state   <= ISSUE;
            end else begin
              dropped <= 1'b1;
            end
          end
        end
        ISSUE: begin
          waitCnt <= CW'(GAP - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == '0) begin
            mode  <= MODE_DISPLAY;
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt - CW'(1);
          end
        end
        default: begin
          mode  <= MODE_DISPLAY;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_cmd_queue.sv
module tb_intersection_cmd_queue;

  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmdValid;
  logic [1:0] cmdOp;
  logic [4:0] cmdPlate;
  logic       cmdReady;
  logic [4:0] numOfCarsA;
  logic [4:0] numOfCarsB;
  logic [2:0] mode;
  logic [4:0] plateIn;
  logic       action;
  logic       dropped;
  logic [2:0] occupancy;

  intersection_cmd_queue #(.DEPTH(4), .GAP(GAP), .MAXCARS(30)) dut (
    .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmdOp(cmdOp),
    .cmdPlate(cmdPlate), .cmdReady(cmdReady), .numOfCarsA(numOfCarsA),
    .numOfCarsB(numOfCarsB), .mode(mode), .plateIn(plateIn),
    .action(action), .dropped(dropped), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [4:0] plate;
    bit         drop;
  } exp_t;

  exp_t sbQ[$];
  exp_t mE;
  int   nCompared = 0;
  int   nMismatch = 0;
  int   cyc = 0;
  int   lastAct = -1;
  bit   checkPace = 1'b0;

  always @(posedge clk) cyc++;

  // Reference legality from the bench's own view of the counts
  function automatic bit expDrop(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [4:0] t;
    t = op[0] ? b : a;
    if (op[1]) return (t >= 5'd30);
    return (t == 5'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sbPush(input logic [1:0] op, input logic [4:0] plate);
    exp_t e;
    e.op = op;
    e.plate = plate;
    e.drop = expDrop(op, numOfCarsA, numOfCarsB);
    sbQ.push_back(e);
  endtask

  // Output monitor: every action/dropped pulse is matched against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && (action || dropped)) begin
      nCompared++;
      if (action && dropped) begin
        nMismatch++;
        $display("FAIL overlap: action=%b dropped=%b required not both high", action, dropped);
      end
      nCompared++;
      if (sbQ.size() == 0) begin
        nMismatch++;
        $display("FAIL unexpected_pulse: action=%b dropped=%b with no command pending", action, dropped);
      end else begin
        mE = sbQ.pop_front();
        if (dropped !== mE.drop) begin
          nMismatch++;
          $display("FAIL sb_kind: dropped=%b required %b (plate %0d)", dropped, mE.drop, mE.plate);
        end else if (!mE.drop) begin
          nCompared++;
          if (mode !== {1'b0, mE.op} || plateIn !== mE.plate) begin
            nMismatch++;
            $display("FAIL sb_issue: mode=%b plateIn=%0d required mode=%b plateIn=%0d",
                     mode, plateIn, {1'b0, mE.op}, mE.plate);
          end
        end
        if (checkPace && action) begin
          if (lastAct >= 0) begin
            nCompared++;
            if (cyc - lastAct != 2 + GAP) begin
              nMismatch++;
              $display("FAIL pace: action spacing %0d required %0d", cyc - lastAct, 2 + GAP);
            end
          end
          lastAct = cyc;
        end
      end
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 200 && sbQ.size() != 0; i++) tick();
    if (sbQ.size() != 0) begin
      nCompared++;
      nMismatch++;
      $display("FAIL drain_timeout: %0d commands outstanding required 0", sbQ.size());
      sbQ.delete();
    end
    repeat (GAP + 3) tick();
    nCompared++;
    if (occupancy !== 3'd0 || mode !== 3'b100) begin
      nMismatch++;
      $display("FAIL drain_idle: occupancy=%0d mode=%b required 0 / 100", occupancy, mode);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmdValid = 1'b1;
    cmdOp = 2'b10;
    cmdPlate = 5'd3;
    numOfCarsA = 5'd0;
    numOfCarsB = 5'd0;
    repeat (3) tick();
    nCompared++;
    if (mode !== 3'b100 || action !== 1'b0 || dropped !== 1'b0 || plateIn !== 5'd0) begin
      nMismatch++;
      $display("FAIL reset_outputs: mode=%b action=%b dropped=%b plateIn=%0d required 100/0/0/0",
               mode, action, dropped, plateIn);
    end
    nCompared++;
    if (occupancy !== 3'd0 || cmdReady !== 1'b1) begin
      nMismatch++;
      $display("FAIL reset_fifo: occupancy=%0d cmdReady=%b required 0/1", occupancy, cmdReady);
    end
    cmdValid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_add();
    numOfCarsA = 5'd0;
    numOfCarsB = 5'd0;
    cmdValid = 1'b1;
    cmdOp = 2'b10;
    cmdPlate = 5'd5;
    @(posedge clk);
    sbPush(2'b10, 5'd5);
    #1;
    cmdValid = 1'b0;
    tick();
    nCompared++;
    if (action !== 1'b1 || mode !== 3'b010 || plateIn !== 5'd5) begin
      nMismatch++;
      $display("FAIL single_k1: action=%b mode=%b plateIn=%0d required 1/010/5", action, mode, plateIn);
    end
    tick();
    nCompared++;
    if (action !== 1'b0 || mode !== 3'b010) begin
      nMismatch++;
      $display("FAIL single_k2: action=%b mode=%b required 0/010", action, mode);
    end
    tick();
    nCompared++;
    if (mode !== 3'b100 || plateIn !== 5'd5) begin
      nMismatch++;
      $display("FAIL single_k3: mode=%b plateIn=%0d required 100/5", mode, plateIn);
    end
    waitDrain();
  endtask

  task automatic test_fill();
    int accepted = 0;
    logic rdy;
    numOfCarsA = 5'd10;
    numOfCarsB = 5'd10;
    checkPace = 1'b1;
    lastAct = -1;
    cmdValid = 1'b1;
    cmdOp = 2'b11;
    for (int i = 0; i < 20 && accepted < 6; i++) begin
      cmdPlate = 5'(accepted + 1);
      rdy = cmdReady;
      @(posedge clk);
      if (rdy) begin
        sbPush(2'b11, 5'(accepted + 1));
        accepted++;
      end
      #1;
    end
    nCompared++;
    if (occupancy !== 3'd4 || cmdReady !== 1'b0) begin
      nMismatch++;
      $display("FAIL fill_full: occupancy=%0d cmdReady=%b required 4/0", occupancy, cmdReady);
    end
    // full FIFO ignores cmdValid
    cmdPlate = 5'd31;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    waitDrain();
    checkPace = 1'b0;
  endtask

  task automatic test_remove_empty();
    numOfCarsA = 5'd4;
    numOfCarsB = 5'd0;
    cmdValid = 1'b1;
    cmdOp = 2'b01;
    cmdPlate = 5'd3;
    @(posedge clk);
    sbPush(2'b01, 5'd3);
    #1;
    cmdOp = 2'b11;
    cmdPlate = 5'd7;
    @(posedge clk);
    sbPush(2'b11, 5'd7);
    #1;
    cmdValid = 1'b0;
    nCompared++;
    if (dropped !== 1'b1 || action !== 1'b0 || mode !== 3'b100) begin
      nMismatch++;
      $display("FAIL rem_empty_drop: dropped=%b action=%b mode=%b required 1/0/100", dropped, action, mode);
    end
    tick();
    nCompared++;
    if (dropped !== 1'b0 || action !== 1'b1 || plateIn !== 5'd7 || mode !== 3'b011) begin
      nMismatch++;
      $display("FAIL rem_empty_next: dropped=%b action=%b plateIn=%0d mode=%b required 0/1/7/011",
               dropped, action, plateIn, mode);
    end
    waitDrain();
  endtask

  task automatic test_add_cap();
    int val [2] = '{30, 29};
    for (int j = 0; j < 2; j++) begin
      numOfCarsA = 5'(val[j]);
      numOfCarsB = 5'd0;
      cmdValid = 1'b1;
      cmdOp = 2'b10;
      cmdPlate = 5'd9;
      @(posedge clk);
      sbPush(2'b10, 5'd9);
      #1;
      cmdValid = 1'b0;
      tick();
      nCompared++;
      if (dropped !== (j == 0) || action !== (j == 1)) begin
        nMismatch++;
        $display("FAIL add_cap_%0d: dropped=%b action=%b required %b/%b",
                 val[j], dropped, action, (j == 0), (j == 1));
      end
      waitDrain();
    end
  endtask

  task automatic test_reset_mid();
    logic rdy;
    int acts = 0;
    numOfCarsA = 5'd0;
    numOfCarsB = 5'd0;
    cmdValid = 1'b1;
    cmdOp = 2'b10;
    for (int i = 0; i < 5; i++) begin
      cmdPlate = 5'(11 + i);
      rdy = cmdReady;
      @(posedge clk);
      if (rdy) sbPush(2'b10, 5'(11 + i));
      #1;
    end
    cmdValid = 1'b0;
    nCompared++;
    if (action !== 1'b1 || occupancy !== 3'd3) begin
      nMismatch++;
      $display("FAIL mid_setup: action=%b occupancy=%0d required 1/3", action, occupancy);
    end
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (action !== 1'b0 || occupancy !== 3'd0 || mode !== 3'b100 || cmdReady !== 1'b1) begin
      nMismatch++;
      $display("FAIL mid_reset: action=%b occupancy=%0d mode=%b cmdReady=%b required 0/0/100/1",
               action, occupancy, mode, cmdReady);
    end
    sbQ.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (action) acts++;
    end
    nCompared++;
    if (acts != 0) begin
      nMismatch++;
      $display("FAIL mid_after: %0d action pulses required 0", acts);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fill();
    test_remove_empty();
    test_add_cap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intersection_cmd_queue.md
# intersection_cmd_queue

Upstream command front-end for `IntersectionSimulator`. It accepts car arrival and departure requests through a valid/ready handshake and buffers them in a small FIFO. It replays them to the simulator as `mode`/`plateIn`/`action` sequences, one command at a time with a guaranteed settling gap. Commands that the simulator's current car counts make illegal are discarded and flagged. While idle it holds the simulator in display mode.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `GAP`, 1: idle cycles after each issued command, ≥1.
- `MAXCARS`, 30: car count at which add commands are discarded.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmdValid`  in  1  producer has a command.
- `cmdOp`  in  2  00 remA, 01 remB, 10 addA, 11 addB.
- `cmdPlate`  in  5  plate number.
- `cmdReady`  out  1  `!full`, combinational.
- `numOfCarsA`  in  5  current road A count, driven by the simulator.
- `numOfCarsB`  in  5  current road B count, driven by the simulator.
- `mode`  out  3  to the simulator; 3'b100 means display.
- `plateIn`  out  5  to the simulator.
- `action`  out  1  to the simulator; one-cycle high pulse per issued command.
- `dropped`  out  1  one-cycle pulse when a command is discarded.
- `occupancy`  out  clog2(DEPTH)+1  FIFO entry count.

## Operation

- **Push:** an entry is written on a rising edge when `cmdValid && cmdReady`.
- **Simultaneous push and pop:** when not full, both occur on the same edge and occupancy is unchanged.
- **Full:** when full, `cmdReady`=0 and `cmdValid` is ignored.
- **FSM states:**
  - IDLE: `mode`=3'b100, `action`=0. If the FIFO is non-empty, pop the head and check legality against `numOfCarsA`/`numOfCarsB` sampled on the same edge.
    - Legal command: go to ISSUE.
    - Illegal command: `dropped`=1 for one cycle, remain in IDLE; the next head is evaluated on the following edge.
  - ISSUE (1 cycle): `mode`={1'b0,op}, `plateIn`=plate, `action`=1. Then go to WAIT.
  - WAIT (GAP cycles): `action`=0; `mode` and `plateIn` hold the issued values; a down-counter of width clog2(GAP+1) runs. Then go to IDLE.
- **Legality rules:**
  - Add is illegal if the target count ≥ `MAXCARS`.
  - Remove is illegal if the target count == 0.
  - All other commands are legal.
- **Stale counts:** WAIT guarantees the simulator has updated its counts before the next legality check. The block keeps no shadow copy of the counts.
- **Other outputs:** `plateIn` keeps its last issued value in IDLE. All outputs are registered except `cmdReady`.
- **Pointers:** read and write pointers wrap modulo DEPTH. Occupancy is kept as a separate counter, so full and empty are unambiguous.

## Timing

- **Reset values (asserted asynchronously):**
  - `mode`=3'b100, `plateIn`=0, `action`=0, `dropped`=0, `occupancy`=0, `cmdReady`=1.
  - State is IDLE and the FIFO is emptied.
- **Reset mid-operation:** `action` drops immediately and queued commands are lost. After `rst_n` rises, the first edge acts as a normal IDLE edge.
- **Latency:** a command accepted at edge k into an empty FIFO while in IDLE is popped at edge k+1. Either `action`=1 during cycle k+1..k+2, or `dropped`=1 for that cycle.
- **Issue pacing:** `action` falls at k+2. `mode` returns to 3'b100 at edge k+2+GAP.
- **Throughput:**
  - One issued command per 2+GAP cycles.
  - One dropped command per cycle.
- **Drop timing:** `dropped` and `action` are never high in the same cycle.

## Test plan

- **Reset:** hold `rst_n`=0 with `cmdValid`=1 → `mode`=100, `action`=0, `occupancy`=0, `cmdReady`=1, and no push occurs.
- **Single add:** counts 0; push addA plate 5 at edge k → at k+1 `mode`=010, `plateIn`=5, `action`=1; at k+2 `action`=0 and `mode`=010; at k+3 (GAP=1) `mode`=100.
- **Fill:** counts A=B=10; push addB on every edge with `cmdValid` held → occupancy reaches 4 after the 6th accepted push and `cmdReady`=0. Commands issue every 3 cycles in push order, with plates verified.
- **Remove from empty road:** `numOfCarsB`=0; push remB then addB plate 7 → `dropped`=1 for one cycle with `action`=0 and `mode`=100. Then addB issues one edge later with `plateIn`=7.
- **Add at cap:** `numOfCarsA`=30; push addA → `dropped` pulse and no `action` pulse. With `numOfCarsA`=29, the same command issues.
- **Reset mid-issue:** drop `rst_n` while `action`=1 with 3 entries queued → `action`=0 and `occupancy`=0 immediately. After release, no `action` pulse occurs.
